n_bit_full_adder: RTL and testbench
===================================

Name: n_bit_full_adder

Overview:
- Parameterised unsigned ripple-carry adder: adds two WIDTH-bit operands and produces a WIDTH-bit sum plus carry-out.
- Datapath is a chain of 1-bit full-adder cells; result is captured in an output register, so latency is one clock.
- Used as a leaf arithmetic block wherever a registered N-bit add with carry-out is needed.
- Default configuration is 8 bits.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a and b are valid this cycle.
- a  input  WIDTH  unsigned operand A.
- b  input  WIDTH  unsigned operand B.
- sum  output  WIDTH  registered low WIDTH bits of a+b.
- cout  output  1  registered carry-out (bit WIDTH of a+b).
- out_valid  output  1  sum/cout hold a result produced from the previous cycle's inputs.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: while rst_n=0, sum=0, cout=0 and out_valid=0, asynchronously, regardless of clk.
- Combinational stage: ripple chain of WIDTH full-adder cells.
  - Cell 0 has carry-in tied to 0; there is no external carry-in.
  - Cell i computes s_i = a_i ^ b_i ^ c_i and c_(i+1) = majority(a_i, b_i, c_i).
  - The last cell's carry is cout_next.
- Register stage, at each rising clk edge with rst_n=1:
  - If in_valid=1: {cout, sum} <= a + b as a (WIDTH+1)-bit result, and out_valid <= 1.
  - If in_valid=0: sum and cout hold their previous values, and out_valid <= 0.
- Latency: exactly 1 cycle from in_valid sampled high to out_valid high with the matching result.
- Throughput: one add per cycle, with no backpressure and no stall.
- Arithmetic is unsigned, with no saturation.
  - Overflow appears only in cout; sum wraps modulo 2^WIDTH.
  - Maximum case: (2^WIDTH-1)+(2^WIDTH-1) gives sum = 2^WIDTH-2, cout = 1.
- Reset mid-operation:
  - A result in flight is discarded and outputs go to 0 immediately.
  - After rst_n rises, the first in_valid=1 edge produces the first valid result one cycle later.
- Inputs are sampled only on clock edges. Changes to a and b between edges have no effect on the outputs.
- X on a or b while in_valid=0 must not corrupt the held outputs.

Decomposition:
- Shared package adder_pkg holds:
  - constant ADDER_DEFAULT_WIDTH = 8;
  - constant ADDER_MAX_WIDTH = 64.
- Sub-module full_adder_bit: 1-bit cell with inputs a, b, cin and outputs s, cout.
  - It is purely combinational.
  - It is instantiated WIDTH times in a generate loop to form the ripple chain.
- Top-level n_bit_full_adder contains:
  - the generate chain;
  - the output register with asynchronous reset;
  - an elaboration-time check that 1 <= WIDTH <= ADDER_MAX_WIDTH.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with prior result sum=0x5A -> sum=0x00, cout=0, out_valid=0 immediately, without waiting for a clock edge.
- Basic add: a=0x03, b=0x04, in_valid=1 -> next cycle sum=0x07, cout=0, out_valid=1.
- Carry and wrap: a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0xFF, b=0xFF -> sum=0xFE, cout=1; a=0x80, b=0x80 -> sum=0x00, cout=1.
- Hold behaviour: result sum=0x10 latched, then in_valid=0 with a=0xAA, b=0x55 -> sum stays 0x10, cout stays 0, out_valid=0.
- Exhaustive sweep (WIDTH=8): all 256x256 (a, b) pairs streamed back-to-back with in_valid=1 -> every cycle {cout, sum} equals the previous cycle's a+b (9-bit), and out_valid stays 1 throughout.
- Parameter check: WIDTH=1 gives 1+1 -> sum=0, cout=1; WIDTH=16 gives 0xFFFF+0x0001 -> sum=0x0000, cout=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the ripple-carry adder family.
package adder_pkg;

    localparam int ADDER_DEFAULT_WIDTH = 8;
    localparam int ADDER_MAX_WIDTH     = 64;

endpackage : adder_pkg

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell: the building block of the ripple chain.
// Purely combinational; the carry out is the majority of the three inputs.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_bit

// File: rtl/n_bit_full_adder.sv
// Registered unsigned WIDTH-bit ripple-carry adder with carry-out.
// The combinational result of the cell chain is captured one clock later
// together with a valid flag that mirrors the sampled in_valid.
module n_bit_full_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    // Reject unsupported widths while elaborating, before any hardware exists.
    generate
        if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_width_check
            $error("n_bit_full_adder: WIDTH=%0d outside 1..%0d", WIDTH, ADDER_MAX_WIDTH);
        end
    endgenerate

    // Carry rail: w_carry[i] feeds cell i, w_carry[WIDTH] is the carry-out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    // There is no external carry-in; the chain starts from zero.
    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_bit u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_carry[i]),
            .s    (w_sum[i]),
            .cout (w_carry[i+1])
        );
    end

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;

    // Output register: load the chain result on a valid beat, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so ordering of these statements cannot matter.
            r_out_valid <= in_valid;
            // NOTE: the load is gated by in_valid rather than muxing a default,
            // so garbage or X on a/b during idle cycles never reaches r_sum.
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[WIDTH];
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_out_valid;

endmodule : n_bit_full_adder

// File: tb/tb_n_bit_full_adder.sv
// Self-checking bench for n_bit_full_adder at WIDTH = 8, 1 and 16.
// A behavioural model predicts {out_valid, cout, sum} from plain integer
// addition; a compare process checks every DUT on every falling edge, and
// directed literal checks pin the model to hand-computed values.
module tb_n_bit_full_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;

    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        cout8, ov8;
    logic [0:0]  a1 = '0, b1 = '0, sum1;
    logic        cout1, ov1;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        cout16, ov16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    n_bit_full_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a8), .b(b8), .sum(sum8), .cout(cout8), .out_valid(ov8)
    );

    n_bit_full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a1), .b(b1), .sum(sum1), .cout(cout1), .out_valid(ov1)
    );

    n_bit_full_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a16), .b(b16), .sum(sum16), .cout(cout16), .out_valid(ov16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: the last accepted addition as an integer, plus the
    // valid flag of the most recent edge. Reset clears everything at once.
    int unsigned exp_r8, exp_r1, exp_r16;
    logic        exp_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_r8    = 0;
            exp_r1    = 0;
            exp_r16   = 0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = in_valid;
            if (in_valid) begin
                exp_r8  = int'(a8) + int'(b8);
                exp_r1  = int'(a1) + int'(b1);
                exp_r16 = int'(a16) + int'(b16);
            end
        end
    end

    // Compare every DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("cmp_w8",  64'({ov8,  cout8,  sum8}),  64'({exp_valid, exp_r8[8:0]}));
        check("cmp_w1",  64'({ov1,  cout1,  sum1}),  64'({exp_valid, exp_r1[1:0]}));
        check("cmp_w16", 64'({ov16, cout16, sum16}), 64'({exp_valid, exp_r16[16:0]}));
    end

    // Present one beat of inputs just after a falling edge.
    task automatic apply(input logic [7:0] va8, input logic [7:0] vb8,
                         input logic va1, input logic vb1,
                         input logic [15:0] va16, input logic [15:0] vb16,
                         input logic v);
        @(negedge clk);
        #1;
        a8 = va8;   b8 = vb8;
        a1 = va1;   b1 = vb1;
        a16 = va16; b16 = vb16;
        in_valid = v;
    endtask

    // Literal expectation for the 8-bit DUT.
    task automatic expect8(input string name, input logic [7:0] s,
                           input logic c, input logic v);
        check({name, "_sum"},   64'(sum8),  64'(s));
        check({name, "_cout"},  64'(cout8), 64'(c));
        check({name, "_valid"}, 64'(ov8),   64'(v));
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        expect8("reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Basic add.
        apply(8'h03, 8'h04, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b1);
        @(negedge clk);
        expect8("basic", 8'h07, 1'b0, 1'b1);
        check("w1_sum",   64'(sum1),   64'd0);
        check("w1_cout",  64'(cout1),  64'd1);
        check("w16_sum",  64'(sum16),  64'h0000);
        check("w16_cout", 64'(cout16), 64'd1);

        // Carry and wrap.
        apply(8'hFF, 8'h01, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        expect8("wrap_ff_01", 8'h00, 1'b1, 1'b1);
        apply(8'hFF, 8'hFF, 1'b0, 1'b1, 16'h1234, 16'h4321, 1'b1);
        @(negedge clk);
        expect8("max_ff_ff", 8'hFE, 1'b1, 1'b1);
        check("w16_plain", 64'({cout16, sum16}), 64'h0_5555);
        apply(8'h80, 8'h80, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        expect8("wrap_80_80", 8'h00, 1'b1, 1'b1);

        // Hold: latch 0x10, then idle with new operands, then idle with X.
        apply(8'h08, 8'h08, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        expect8("latch_10", 8'h10, 1'b0, 1'b1);
        apply(8'hAA, 8'h55, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        @(negedge clk);
        expect8("hold", 8'h10, 1'b0, 1'b0);
        apply(8'hxx, 8'hxx, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        expect8("hold_x", 8'h10, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with result 0x5A registered.
        apply(8'h2D, 8'h2D, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        expect8("pre_reset", 8'h5A, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        expect8("async_reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        apply(8'h11, 8'h22, 1'b1, 1'b0, 16'h8000, 16'h8000, 1'b1);
        @(negedge clk);
        expect8("after_reset", 8'h33, 1'b0, 1'b1);

        // Randomised traffic on all three widths.
        for (int n = 0; n < 400; n++) begin
            apply(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Exhaustive 8-bit sweep, streamed back-to-back.
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                apply(8'(i), 8'(j), 1'(i), 1'(j), 16'(i * 257), 16'(j * 255), 1'b1);
            end
        end
        @(negedge clk);
        expect8("sweep_last", 8'hFE, 1'b1, 1'b1);

        apply(8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_n_bit_full_adder
